// File: rtl/clk_divider.sv
// clk_divider: integer clock divider with a 50% duty div_clk, a source-domain tick and a phase count.
// Odd ratios use a falling-edge copy of the posedge flop to add the half source period that 50% duty needs.
module clk_divider #(
    parameter int DIVIDER = 10
) (
    input  logic                       clk_out,
    input  logic                       rst,
    input  logic                       en,
    output logic                       div_clk,
    output logic                       div_tick,
    output logic [$clog2(DIVIDER)-1:0] phase
);
    localparam int W = $clog2(DIVIDER);
    localparam logic [W-1:0] LAST = W'(DIVIDER - 1);
    localparam logic [W-1:0] RISE = W'(DIVIDER / 2 - 1);
    localparam logic [W-1:0] FALL = W'((DIVIDER % 2 == 1) ? DIVIDER - 2 : DIVIDER - 1);

    if (DIVIDER < 2) begin : g_bad
        $error("clk_divider: DIVIDER must be >= 2");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         qp_q, qp_d, tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        qp_d   = qp_q;
        tick_d = 1'b0;
        if (en) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            qp_d   = (cnt_q == RISE || cnt_q == FALL) ? ~qp_q : qp_q;
            tick_d = (cnt_q == RISE);
        end
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            qp_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            qp_q   <= qp_d;
            tick_q <= tick_d;
        end
    end

    if (DIVIDER % 2 == 1) begin : g_odd
        logic qn_q;
        always_ff @(negedge clk_out or negedge rst) begin
            if (!rst) qn_q <= 1'b0;
            else      qn_q <= qp_q;
        end
        assign div_clk = qp_q | qn_q;
    end else begin : g_even
        assign div_clk = qp_q;
    end

    assign div_tick = tick_q;
    assign phase    = cnt_q;
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: three dividers (10, 3, 2) on one source clock, checked every half cycle
// against a phase-count model, plus literal timing measurements of the divided clocks.
module tb_clk_divider;
    logic clk_out = 1'b0;
    logic rst, en;
    logic [2:0] dv, tk;
    logic [3:0] ph10;
    logic [1:0] ph3;
    logic       ph2;
    logic [31:0] aph [3];
    int vectors = 0, errs = 0;
    int N [3] = '{10, 3, 2};
    int p [3], pp [3];
    bit st [3];
    realtime lr [3], per [3], hi_t [3], fr [3];
    int nr [3];
    int nt10 = 0;

    always #10 clk_out = ~clk_out;

    clk_divider #(.DIVIDER(10)) u10 (.clk_out(clk_out), .rst(rst), .en(en), .div_clk(dv[0]), .div_tick(tk[0]), .phase(ph10));
    clk_divider #(.DIVIDER(3))  u3  (.clk_out(clk_out), .rst(rst), .en(en), .div_clk(dv[1]), .div_tick(tk[1]), .phase(ph3));
    clk_divider #(.DIVIDER(2))  u2  (.clk_out(clk_out), .rst(rst), .en(en), .div_clk(dv[2]), .div_tick(tk[2]), .phase(ph2));

    assign aph[0] = 32'(ph10);
    assign aph[1] = 32'(ph3);
    assign aph[2] = 32'(ph2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Divided clock is high over the second half of the count range, odd ratios offset by half a cycle
    function automatic bit hi(input int n, input int c);
        return (n % 2 == 0) ? (c >= n / 2) : (c >= (n - 1) / 2 && c <= n - 2);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_m
        always @(posedge dv[g]) begin
            if (nr[g] == 0) fr[g] = $realtime;
            per[g] = $realtime - lr[g];
            lr[g] = $realtime;
            nr[g]++;
        end
        always @(negedge dv[g]) hi_t[g] = $realtime - lr[g];
    end

    always @(negedge clk_out) if (tk[0]) nt10++;

    initial begin
        forever begin
            @(posedge clk_out);
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin p[i] = 0; pp[i] = 0; st[i] = 0; end
                else if (en) begin pp[i] = p[i]; p[i] = (p[i] + 1) % N[i]; st[i] = 1; end
                else begin pp[i] = p[i]; st[i] = 0; end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin p[i] = 0; pp[i] = 0; st[i] = 0; end
                chk($sformatf("div%0d phase", N[i]), aph[i], 32'(p[i]));
                chk($sformatf("div%0d tick", N[i]), 32'(tk[i]), 32'(st[i] && p[i] == N[i] / 2));
                chk($sformatf("div%0d clk_rise_half", N[i]), 32'(dv[i]),
                    32'(hi(N[i], p[i]) || (N[i] % 2 == 1 && hi(N[i], pp[i]))));
            end
            @(negedge clk_out);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin p[i] = 0; pp[i] = 0; st[i] = 0; end
                pp[i] = p[i];
                chk($sformatf("div%0d clk_fall_half", N[i]), 32'(dv[i]), 32'(hi(N[i], p[i])));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit found;
        rst = 1'b0;
        en = 1'b1;
        #5;
        chk("reset div_clk", 32'(dv), 0);
        chk("reset tick", 32'(tk), 0);
        chk("reset phase10", aph[0], 0);
        #47 rst = 1'b1;
        #2000;
        chk("rises10 in 2000", nr[0], 10);
        chk("ticks10 in 2000", nt10, 10);
        chk("first rise10", int'(fr[0]), 150);
        chk("period10", int'(per[0]), 200);
        chk("high10", int'(hi_t[0]), 100);
        chk("first rise3", int'(fr[1]), 70);
        chk("period3", int'(per[1]), 60);
        chk("high3", int'(hi_t[1]), 30);
        chk("first rise2", int'(fr[2]), 70);
        chk("period2", int'(per[2]), 40);
        chk("high2", int'(hi_t[2]), 20);
        chk("phase10 after 100 edges", aph[0], 0);
        chk("phase3 after 100 edges", aph[1], 1);
        chk("phase2 after 100 edges", aph[2], 0);
        @(posedge clk_out);
        #1;
        chk("phase2 alternates", aph[2], 1);
        chk("phase10 next", aph[0], 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_out);
            #2;
            found = (ph10 == 4'd3);
        end
        chk("reach phase 3", 32'(found), 1);
        en = 1'b0;
        repeat (7) begin
            @(posedge clk_out);
            #1;
            chk("stall phase", aph[0], 3);
            chk("stall tick", 32'(tk[0]), 0);
            chk("stall div_clk", 32'(dv[0]), 0);
        end
        #1 en = 1'b1;
        @(posedge clk_out);
        #1;
        chk("resume phase", aph[0], 4);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_out);
            #5;
            found = dv[0];
        end
        chk("reach div_clk high", 32'(found), 1);
        rst = 1'b0;
        #1;
        chk("async rst div_clk", 32'(dv), 0);
        chk("async rst tick", 32'(tk), 0);
        chk("async rst phase10", aph[0], 0);
        repeat (3) @(posedge clk_out);
        #2 rst = 1'b1;
        k = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_out);
            #1;
            k++;
            found = dv[0];
        end
        chk("restart first rise edge", k, 5);
        repeat (600) begin
            @(posedge clk_out);
            #2;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                #3 rst = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk_out);
                #2 rst = 1'b1;
            end
        end
        en = 1'b1;
        @(posedge clk_out);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
